// File: rtl/calisma_pkg.sv
// Shared types and helpers for the calisma_1 3-input Boolean function evaluator.
package calisma_pkg;

   typedef logic [2:0] minterm_t;

   localparam logic [7:0] TT_DEFAULT = 8'hB8;

   function automatic logic [7:0] onehot8(input minterm_t m);
      return 8'b1 << m;
   endfunction

endpackage

// File: rtl/calisma_1_lut.sv
// Purely combinational truth-table lookup: o_f = TRUTH_TABLE[{i_a,i_b,i_c}].
module calisma_1_lut
   import calisma_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = TT_DEFAULT
) (
   input  logic i_a,
   input  logic i_b,
   input  logic i_c,
   output logic o_f
);

   minterm_t w_minterm;

   assign w_minterm = {i_a, i_b, i_c};
   assign o_f       = TRUTH_TABLE[w_minterm];

endmodule

// File: rtl/calisma_1.sv
// 3-input Boolean function evaluator with registered copy, rise pulse and coverage map.
// Optional macro CALISMA_GATE_CHECK_EN adds a gate-level SOP cross-check and gate_mismatch port.
module calisma_1
   import calisma_pkg::*;
#(
   parameter logic [7:0] TRUTH_TABLE = TT_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       A,
   input  logic       B,
   input  logic       C,
   output logic       F,
   output logic       F_q,
   output logic       F_rise,
   output logic [7:0] seen,
`ifdef CALISMA_GATE_CHECK_EN
   output logic       all_seen,
   output logic       gate_mismatch
`else
   output logic       all_seen
`endif
);

   minterm_t   w_minterm;
   logic       w_f;
   logic [7:0] w_seen_next;

   logic       r_f_q;
   logic       r_f_q_d;
   logic       r_f_rise;
   logic [7:0] r_seen;
   logic       r_all_seen;

   calisma_1_lut #(
      .TRUTH_TABLE (TRUTH_TABLE)
   ) u_lut (
      .i_a (A),
      .i_b (B),
      .i_c (C),
      .o_f (w_f)
   );

   assign w_minterm   = {A, B, C};
   assign w_seen_next = r_seen | onehot8(w_minterm);

   // NOTE: reset is synchronous, so it only takes effect on a clock edge; all state uses <= to avoid ordering races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_f_q      <= 1'b0;
         r_f_q_d    <= 1'b0;
         r_f_rise   <= 1'b0;
         r_seen     <= 8'h00;
         r_all_seen <= 1'b0;
      end else begin
         r_f_q      <= w_f;
         r_f_q_d    <= r_f_q;
         // Pulse follows the edge on which F_q itself went 0->1.
         r_f_rise   <= r_f_q & ~r_f_q_d;
         r_seen     <= w_seen_next;
         r_all_seen <= r_all_seen | (w_seen_next == 8'hFF);
      end
   end

   assign F        = w_f;
   assign F_q      = r_f_q;
   assign F_rise   = r_f_rise;
   assign seen     = r_seen;
   assign all_seen = r_all_seen;

`ifdef CALISMA_GATE_CHECK_EN
   logic w_gate_f;
   logic w_check_en;
   logic r_gate_mismatch;

   assign w_gate_f   = (A & ~B) | (B & C);
   assign w_check_en = (TRUTH_TABLE == TT_DEFAULT);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_gate_mismatch <= 1'b0;
      end else if (w_check_en) begin
         assert (w_gate_f == w_f)
            else $error("calisma_1: gate SOP differs from table at minterm %0d", w_minterm);
         if (w_gate_f != w_f) r_gate_mismatch <= 1'b1;
      end
   end

   assign gate_mismatch = r_gate_mismatch;
`endif

endmodule

// File: tb/tb_calisma_1.sv
// Self-checking bench for calisma_1: directed scenarios plus random stimulus against a behavioural model.
module tb_calisma_1;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       a = 1'b0, b = 1'b0, c = 1'b0;

   logic       f, f_q, f_rise, all_seen;
   logic [7:0] seen;
   logic       x_f, x_f_q, x_f_rise, x_all_seen;
   logic [7:0] x_seen;
`ifdef CALISMA_GATE_CHECK_EN
   logic       gm, x_gm;
`endif

   int n_checks = 0;
   int n_errors = 0;

   // behavioural model state
   bit m_fq, m_fq_prev, m_rise, m_all;
   bit m_seen [8];

   always #5 clk = ~clk;

   calisma_1 dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (a),
      .B        (b),
      .C        (c),
      .F        (f),
      .F_q      (f_q),
      .F_rise   (f_rise),
      .seen     (seen),
`ifdef CALISMA_GATE_CHECK_EN
      .all_seen (all_seen),
      .gate_mismatch (gm)
`else
      .all_seen (all_seen)
`endif
   );

   calisma_1 #(.TRUTH_TABLE(8'h96)) dut_xor (
      .clk      (clk),
      .rst_n    (rst_n),
      .A        (a),
      .B        (b),
      .C        (c),
      .F        (x_f),
      .F_q      (x_f_q),
      .F_rise   (x_f_rise),
      .seen     (x_seen),
`ifdef CALISMA_GATE_CHECK_EN
      .all_seen (x_all_seen),
      .gate_mismatch (x_gm)
`else
      .all_seen (x_all_seen)
`endif
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_f(input bit ia, input bit ib, input bit ic);
      return (ia && !ib) || (ib && ic);
   endfunction

   function automatic logic [7:0] model_seen();
      logic [7:0] v = 8'h00;
      for (int i = 0; i < 8; i++) v[i] = m_seen[i];
      return v;
   endfunction

   function automatic int model_seen_count();
      int n = 0;
      for (int i = 0; i < 8; i++) n += m_seen[i];
      return n;
   endfunction

   // One clock: drive on the falling edge, check F, clock, check registered outputs.
   task automatic step(input bit ia, input bit ib, input bit ic, input bit irst);
      @(negedge clk);
      a = ia; b = ib; c = ic; rst_n = irst;
      #1;
      check("f", f, ref_f(ia, ib, ic));
      check("f_xor", x_f, ia ^ ib ^ ic);
      @(posedge clk);
      if (!irst) begin
         m_fq = 0; m_fq_prev = 0; m_rise = 0; m_all = 0;
         for (int i = 0; i < 8; i++) m_seen[i] = 0;
      end else begin
         m_rise    = m_fq && !m_fq_prev;
         m_fq_prev = m_fq;
         m_fq      = ref_f(ia, ib, ic);
         m_seen[{ia, ib, ic}] = 1;
         if (model_seen_count() == 8) m_all = 1;
      end
      #1;
      check("f_q", f_q, m_fq);
      check("f_rise", f_rise, m_rise);
      check("seen", seen, model_seen());
      check("all_seen", all_seen, m_all);
      check("xor_seen", x_seen, model_seen());
`ifdef CALISMA_GATE_CHECK_EN
      check("gate_mismatch", gm, 1'b0);
`endif
   endtask

   initial begin
      bit exp_sweep [8] = '{0, 0, 0, 1, 1, 1, 0, 1};
      bit [2:0] m;

      step(0, 0, 0, 0);
      step(0, 0, 0, 0);

      // exhaustive sweep
      for (int i = 0; i < 8; i++) begin
         m = 3'(i);
         step(m[2], m[1], m[0], 1);
         check("sweep_f", f, exp_sweep[i]);
      end
      check("sweep_seen", seen, 8'hFF);
      check("sweep_all_seen", all_seen, 1'b1);

      // reset held with 011, then release
      step(0, 1, 1, 0);
      step(0, 1, 1, 0);
      check("rst_f", f, 1'b1);
      check("rst_f_q", f_q, 1'b0);
      check("rst_seen", seen, 8'h00);
      check("rst_all_seen", all_seen, 1'b0);
      step(0, 1, 1, 1);
      check("rel1_f_q", f_q, 1'b1);
      check("rel1_f_rise", f_rise, 1'b0);
      step(0, 1, 1, 1);
      check("rel2_f_rise", f_rise, 1'b1);
      step(0, 1, 1, 1);
      check("rel3_f_rise", f_rise, 1'b0);

      // 000, 011, 000
      step(0, 0, 0, 0);
      step(0, 0, 0, 1);
      step(0, 1, 1, 1);
      step(0, 0, 0, 1);
      check("seq_f_q", f_q, 1'b0);
      check("seq_seen", seen, 8'h09);

      // partial sweep, reset mid-sweep, resume
      step(0, 0, 0, 0);
      for (int i = 0; i <= 5; i++) begin
         m = 3'(i);
         step(m[2], m[1], m[0], 1);
      end
      step(1, 0, 1, 0);
      check("mid_rst_seen", seen, 8'h00);
      step(1, 1, 0, 1);
      step(1, 1, 1, 1);
      check("resume_seen", seen, 8'hC0);
      check("resume_all_seen", all_seen, 1'b0);

      // random stimulus with occasional reset
      for (int i = 0; i < 300; i++) begin
         m = 3'($urandom_range(0, 7));
         step(m[2], m[1], m[0], ($urandom_range(0, 15) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
